// File: rtl/dsp_mem_banks.sv
// ---------------------------------------------------------------------------
// dsp_mem_banks
//
// Purpose:
//   Two independent single-write / single-read register-file banks of depth
//   D = 2^(A-1), words of W bits. After reset an internal sweep writes zero
//   to every index of both banks, one index per cycle. Only after the sweep
//   does the block accept writes and produce read data. Writes that arrive
//   during the sweep are discarded and recorded in a sticky flag.
//
// Widths:
//   A = `MEM_ADDR_LEN, W = `REG_WORD_LEN. These normally come from
//   definitions.v. When that file has not been compiled first, the defaults
//   below are used: A = 8, W = 16.
//
// Optional feature:
//   DSP_MEM_BYPASS_EN
//     Defined:   a read and a write to the same bank and index in the same
//                cycle return the new write data (write-first).
//     Undefined: the read returns the previously stored word (read-first).
//
// Ports:
//   clk           in   1  single clock, rising edge
//   rst           in   1  synchronous active-high reset
//   read_addr_1   in   A  bank-1 read address, MSB ignored
//   read_addr_2   in   A  bank-2 read address, MSB ignored
//   write_addr_2  in   A  write address, MSB selects bank (0 = 1, 1 = 2)
//   write_en      in   1  write strobe
//   write_data    in   W  write data
//   read_data_1   out  W  registered bank-1 read data
//   read_data_2   out  W  registered bank-2 read data
//   mem_ready     out  1  sweep finished, accesses accepted
//   wr_drop       out  1  sticky: a write arrived while not ready
// ---------------------------------------------------------------------------
`ifndef MEM_ADDR_LEN
`define MEM_ADDR_LEN 8
`endif
`ifndef REG_WORD_LEN
`define REG_WORD_LEN 16
`endif

module dsp_mem_banks #(
    parameter int A = `MEM_ADDR_LEN,
    parameter int W = `REG_WORD_LEN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [A-1:0] read_addr_1,
    input  logic [A-1:0] read_addr_2,
    input  logic [A-1:0] write_addr_2,
    input  logic         write_en,
    input  logic [W-1:0] write_data,
    output logic [W-1:0] read_data_1,
    output logic [W-1:0] read_data_2,
    output logic         mem_ready,
    output logic         wr_drop
);

    localparam int IW = A - 1;
    localparam int D  = 1 << IW;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [IW-1:0]  clrIdx_q, clrIdx_d;

    logic [W-1:0]   bank1_q [D];
    logic [W-1:0]   bank2_q [D];

    logic [W-1:0]   rdData1_q, rdData1_d;
    logic [W-1:0]   rdData2_q, rdData2_d;
    logic           wrDrop_q, wrDrop_d;

    logic           clearWe;
    logic           userWe;
    logic           dropEvent;
    logic           isReady;

    logic [IW-1:0]  rdIdx1;
    logic [IW-1:0]  rdIdx2;
    logic [IW-1:0]  wrIdx;
    logic           wrBank;

    // Read-address MSBs carry no meaning for a single bank.
    logic           unusedAddrMsbs;

    assign rdIdx1         = read_addr_1[IW-1:0];
    assign rdIdx2         = read_addr_2[IW-1:0];
    assign wrIdx          = write_addr_2[IW-1:0];
    assign wrBank         = write_addr_2[A-1];
    assign unusedAddrMsbs = read_addr_1[A-1] ^ read_addr_2[A-1];

    // -----------------------------------------------------------------------
    // FSM state register. Holding rst keeps clrIdx at 0, so the sweep always
    // starts from the beginning after any reset.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= CLEAR;
            clrIdx_q <= '0;
        end else begin
            state_q  <= state_d;
            clrIdx_q <= clrIdx_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state. The sweep leaves CLEAR after writing the last index;
    // the counter then freezes instead of wrapping.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        clrIdx_d = clrIdx_q;
        case (state_q)
            CLEAR: begin
                if (clrIdx_q == {IW{1'b1}}) begin
                    state_d = READY;
                end else begin
                    clrIdx_d = clrIdx_q + 1'b1;
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM outputs. Array writes are gated with rst so a write presented in a
    // reset cycle is lost rather than landing in the array.
    // -----------------------------------------------------------------------
    always_comb begin
        isReady   = (state_q == READY);
        clearWe   = (state_q == CLEAR) && !rst;
        userWe    = (state_q == READY) && write_en && !rst;
        dropEvent = (state_q == CLEAR) && write_en;
    end

    // -----------------------------------------------------------------------
    // Storage arrays, deliberately without reset: only the sweep zeroes them.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clearWe) begin
            bank1_q[clrIdx_q] <= '0;
            bank2_q[clrIdx_q] <= '0;
        end else if (userWe) begin
            if (wrBank) begin
                bank2_q[wrIdx] <= write_data;
            end else begin
                bank1_q[wrIdx] <= write_data;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read-data next value. With the bypass enabled, a colliding write in the
    // same bank forwards write_data instead of the stale array word.
    // -----------------------------------------------------------------------
    always_comb begin
        rdData1_d = bank1_q[rdIdx1];
        rdData2_d = bank2_q[rdIdx2];
`ifdef DSP_MEM_BYPASS_EN
        if (userWe && !wrBank && (wrIdx == rdIdx1)) begin
            rdData1_d = write_data;
        end
        if (userWe && wrBank && (wrIdx == rdIdx2)) begin
            rdData2_d = write_data;
        end
`endif
    end

    // -----------------------------------------------------------------------
    // Read-data registers, forced to zero until the sweep is complete.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || !isReady) begin
            rdData1_q <= '0;
            rdData2_q <= '0;
        end else begin
            rdData1_q <= rdData1_d;
            rdData2_q <= rdData2_d;
        end
    end

    // -----------------------------------------------------------------------
    // Sticky dropped-write flag; only reset clears it.
    // -----------------------------------------------------------------------
    always_comb begin
        wrDrop_d = wrDrop_q | dropEvent;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrDrop_q <= 1'b0;
        end else begin
            wrDrop_q <= wrDrop_d;
        end
    end

    assign read_data_1 = rdData1_q;
    assign read_data_2 = rdData2_q;
    assign mem_ready   = isReady;
    assign wr_drop     = wrDrop_q;

endmodule
